// File: rtl/red_seq_ctrl.sv
// red_seq_ctrl: byte-pair reduction sequenced over one 4-bit CLA slice.
// Area-reduced alternative to the combinational reduction unit.

module red_seq_ctrl_cla4 (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = x_i & y_i;
  assign p = x_i ^ y_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];

endmodule

module red_seq_ctrl #(
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO0,
    S_LO1,
    S_HI0,
    S_HI1,
    S_SUM0,
    S_SUM1,
    S_SUMC
  } state_t;

  state_t      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        c_q;
  logic [8:0]  lo_q;
  logic [8:0]  hi_q;
  logic [7:0]  t_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] result_q;

  logic [3:0]  add_x_d;
  logic [3:0]  add_y_d;
  logic        add_c_d;
  logic [3:0]  add_s;
  logic        add_co;

  // Route the nibble pair for the current step into the shared slice.
  always_comb begin
    add_x_d = 4'h0;
    add_y_d = 4'h0;
    add_c_d = 1'b0;
    unique case (state_q)
      S_LO0: begin
        add_x_d = a_q[3:0];
        add_y_d = b_q[3:0];
      end
      S_LO1: begin
        add_x_d = a_q[7:4];
        add_y_d = b_q[7:4];
        add_c_d = c_q;
      end
      S_HI0: begin
        add_x_d = a_q[11:8];
        add_y_d = b_q[11:8];
      end
      S_HI1: begin
        add_x_d = a_q[15:12];
        add_y_d = b_q[15:12];
        add_c_d = c_q;
      end
      S_SUM0: begin
        add_x_d = lo_q[3:0];
        add_y_d = hi_q[3:0];
      end
      S_SUM1: begin
        add_x_d = lo_q[7:4];
        add_y_d = hi_q[7:4];
        add_c_d = c_q;
      end
      S_SUMC: begin
        add_x_d = {3'b000, lo_q[8]};
        add_y_d = {3'b000, hi_q[8]};
        add_c_d = c_q;
      end
      default: begin
        add_x_d = 4'h0;
        add_y_d = 4'h0;
        add_c_d = 1'b0;
      end
    endcase
  end

  red_seq_ctrl_cla4 u_cla (
    .x_i (add_x_d),
    .y_i (add_y_d),
    .c_i (add_c_d),
    .s_o (add_s),
    .c_o (add_co)
  );

  // Step sequencer: control, partial sums and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      c_q      <= 1'b0;
      lo_q     <= 9'h000;
      hi_q     <= 9'h000;
      t_q      <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
    end else if (abort) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_LO0;
          end else if (!DONE_HOLD) begin
            done_q <= 1'b0;
          end
        end
        S_LO0: begin
          lo_q[3:0] <= add_s;
          c_q       <= add_co;
          done_q    <= 1'b0;
          state_q   <= S_LO1;
        end
        S_LO1: begin
          lo_q[7:4] <= add_s;
          lo_q[8]   <= add_co;
          state_q   <= S_HI0;
        end
        S_HI0: begin
          hi_q[3:0] <= add_s;
          c_q       <= add_co;
          state_q   <= S_HI1;
        end
        S_HI1: begin
          hi_q[7:4] <= add_s;
          hi_q[8]   <= add_co;
          state_q   <= S_SUM0;
        end
        S_SUM0: begin
          t_q[3:0] <= add_s;
          c_q      <= add_co;
          state_q  <= S_SUM1;
        end
        S_SUM1: begin
          t_q[7:4] <= add_s;
          c_q      <= add_co;
          state_q  <= S_SUMC;
        end
        S_SUMC: begin
          // Bit 0 of the carry sum is t[8]; it fills the upper byte.
          result_q <= {{8{add_s[0]}}, t_q};
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_red_seq_ctrl.sv
// tb_red_seq_ctrl: scoreboard bench for red_seq_ctrl.
// Two instances share stimulus: pulse done and held done.

module tb_red_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        busy_h;
  logic        done_h;
  logic [15:0] result_h;

  int n_checks;
  int n_pass;

  logic [15:0] sb[$];
  logic [15:0] sbh[$];
  logic [15:0] last_res;
  logic        done_h_prev;

  red_seq_ctrl #(.DONE_HOLD(1'b0)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  red_seq_ctrl #(.DONE_HOLD(1'b1)) dut_h (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .a      (a),
    .b      (b),
    .busy   (busy_h),
    .done   (done_h),
    .result (result_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  // Reduction defined from byte sums, independent of nibble steps.
  function automatic logic [15:0] model(input logic [15:0] x,
                                        input logic [15:0] y);
    int lo;
    int hi;
    int t;
    lo = int'(x[7:0]) + int'(y[7:0]);
    hi = int'(x[15:8]) + int'(y[15:8]);
    t  = (lo + hi) % 512;
    if (t >= 256) return 16'hFF00 | 16'(t % 256);
    return 16'(t);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every done (pulse instance) and every rising done
  // (held instance) must match the next queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      done_h_prev <= 1'b0;
    end else begin
      if (done) begin
        chk("done_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0)
          chk("result", 32'(result), 32'(sb.pop_front()));
      end
      if (done_h && !done_h_prev) begin
        chk("h_done_expected", 32'(sbh.size() > 0), 32'd1);
        if (sbh.size() > 0)
          chk("h_result", 32'(result_h), 32'(sbh.pop_front()));
      end
      done_h_prev <= done_h;
    end
  end

  // Issue one op from IDLE; returns in the done cycle.
  task automatic run_op(input logic [15:0] xa,
                        input logic [15:0] xb);
    int cyc;
    int bcnt;
    start = 1'b1;
    a = xa;
    b = xb;
    sb.push_back(model(xa, xb));
    sbh.push_back(model(xa, xb));
    step(1);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    chk("h_done_clr_on_start", 32'(done_h), 32'd0);
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      step(1);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd7);
    chk("busy_cycles", 32'(bcnt), 32'd7);
    chk("busy_at_done", 32'(busy), 32'd0);
    last_res = model(xa, xb);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    last_res = 16'h0000;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a = 16'h0000;
    b = 16'h0000;

    repeat (2) begin
      @(negedge clk);
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_done_h", 32'(done_h), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_result", 32'(result), 32'h0);

    run_op(16'h0101, 16'h0101);
    step(1);
    run_op(16'hFFFF, 16'hFFFF);
    step(1);
    run_op(16'h00FF, 16'h0001);
    run_op(16'h8080, 16'h8080);
    step(2);

    // Back-to-back with a start that lands while busy.
    start = 1'b1;
    a = 16'h1234;
    b = 16'h0000;
    sb.push_back(model(16'h1234, 16'h0000));
    sbh.push_back(model(16'h1234, 16'h0000));
    step(1);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    step(2);
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    step(1);
    start = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (!done && cyc < 10) begin
        step(1);
        cyc++;
      end
      chk("b2b_first_latency", 32'(cyc), 32'd4);
    end
    last_res = model(16'h1234, 16'h0000);
    run_op(16'h0001, 16'h0002);

    // Held done stays up while idle; pulse done drops.
    repeat (3) begin
      step(1);
      chk("pulse_done_low", 32'(done), 32'd0);
      chk("hold_done_high", 32'(done_h), 32'd1);
    end

    // Abort in HI1.
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    step(1);
    start = 1'b0;
    step(3);
    chk("busy_before_abort", 32'(busy), 32'd1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_busy_h", 32'(busy_h), 32'd0);
    repeat (8) begin
      step(1);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_done_h", 32'(done_h), 32'd0);
      chk("abort_result_kept", 32'(result), 32'(last_res));
    end
    run_op(16'h1357, 16'h2468);
    step(1);

    // Abort with start in IDLE: start dropped, held done clears.
    chk("hold_done_pre", 32'(done_h), 32'd1);
    start = 1'b1;
    abort = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_done_h", 32'(done_h), 32'd0);
    step(3);
    chk("idle_abort_still_idle", 32'(busy), 32'd0);

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] xa;
      logic [15:0] xb;
      int gap;
      xa = 16'($urandom);
      xb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) xa[7:0] = 8'hFF;
      if ($urandom_range(0, 3) == 0) xb[15:8] = 8'hFF;
      run_op(xa, xb);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step(1);
        chk("gap_done", 32'(done), 32'd0);
        chk("gap_done_h", 32'(done_h), 32'd1);
      end
    end

    // Async reset during SUM0, between clock edges.
    step(1);
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    step(1);
    start = 1'b0;
    step(4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", 32'(result), 32'h0);
    chk("arst_busy_h", 32'(busy_h), 32'd0);
    chk("arst_result_h", 32'(result_h), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_res = 16'h0000;
    step(8);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_result", 32'(result), 32'(last_res));
    run_op(16'h7F80, 16'h0080);
    step(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sbh_drained", 32'(sbh.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d/%0d so far",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/red_seq_ctrl.md
Name: red_seq_ctrl

Overview:
- Multi-cycle sequencer that computes the 16-bit RED (byte-pair reduction) result by time-sharing a single 4-bit carry-lookahead adder slice, instead of using seven parallel slices.
- Sits in the ALU next to the combinational reduction unit as the area-reduced alternative.
- The pipeline starts it with a one-cycle start pulse, stalls on busy, and takes the result when done pulses.

Parameters:
- DONE_HOLD, 0: 0 = done is a single-cycle pulse; 1 = done stays high in IDLE until the next accepted start or abort.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous flush of an in-flight operation.
- a  input  16  operand A (AAAAAAAA_BBBBBBBB).
- b  input  16  operand B (CCCCCCCC_DDDDDDDD).
- busy  output  1  high while a step state is active.
- done  output  1  result-valid strobe.
- result  output  16  reduction result, held until the next completion.

Behaviour:
- Reset: the async assertion of rst forces:
  - state=IDLE, busy=0, done=0, result=16'h0000;
  - operand registers = 0, carry register = 0, lo/hi partial registers = 0.
- Arithmetic contract (the bench checks against this model):
  - lo = a[7:0] + b[7:0], 9 bits.
  - hi = a[15:8] + b[15:8], 9 bits.
  - t = lo + hi, 10 bits; t[9] is discarded.
  - result = {{8{t[8]}}, t[7:0]}.
- One 4-bit adder instance, carry in from the 1-bit carry register; its carry out is written back each step.
- States and the step performed on the edge that leaves each state:
  - IDLE: if start (and not abort), latch a/b, clear carry, go LO0.
  - LO0: a[3:0]+b[3:0], cin=0. Write lo[3:0], capture carry. Go LO1.
  - LO1: a[7:4]+b[7:4]+c. Write lo[7:4]; lo[8]=cout. Go HI0.
  - HI0: a[11:8]+b[11:8], cin=0. Write hi[3:0], capture carry. Go HI1.
  - HI1: a[15:12]+b[15:12]+c. Write hi[7:4]; hi[8]=cout. Go SUM0.
  - SUM0: lo[3:0]+hi[3:0], cin=0. Write t[3:0]. Go SUM1.
  - SUM1: lo[7:4]+hi[7:4]+c. Write t[7:4]. Go SUMC.
  - SUMC: {3'b0,lo[8]}+{3'b0,hi[8]}+c. Write result (sign-extend from bit 0 of this sum). Assert done. Go IDLE.
- Latency:
  - Start is accepted at edge E0. Result and done are visible in the cycle after edge E7, so 7 cycles.
  - busy is high from after E0 through E7.
- Back-to-back: start is accepted in the same cycle that done is high, since state is already IDLE. The next result follows 7 cycles later.
- start while busy: ignored, not queued; operand registers are unchanged.
- abort:
  - Takes priority over everything except rst.
  - In any step state the next edge goes to IDLE, busy=0, no done; result keeps its previous value.
  - In IDLE, abort with start: start is dropped; with DONE_HOLD=1, done clears.
- DONE_HOLD=0: done deasserts on the next edge regardless of inputs.
- Inputs a/b may change freely after the start edge; only latched copies are used.
- rst mid-operation: immediate return to the reset values above; the partial result is lost.

Test Plan:
- Reset then idle: hold rst 2 cycles with start=0 -> result=0x0000, busy=0, done=0 throughout.
- Basic: a=0x0101, b=0x0101, start one cycle -> busy for 7 cycles, then done=1 with result=0x0004.
- Sign extension:
  - a=0xFFFF, b=0xFFFF -> result=0xFFFC.
  - a=0x00FF, b=0x0001 -> result=0xFF00.
  - a=0x8080, b=0x8080 -> result=0x0000 (t[9] dropped).
- Back-to-back with ignored start:
  - First op a=0x1234, b=0x0000 -> result=0x0046.
  - A second start pulse at cycle 3 is ignored.
  - A start raised in the done cycle with a=0x0001, b=0x0002 -> second done 7 cycles later, result=0x0003.
- Abort: start a=0xFFFF, b=0xFFFF, then abort in state HI1 -> busy drops the next cycle, no done pulse, result keeps its prior value; a following start completes normally.
- Async reset mid-op: assert rst between edges during SUM0 -> busy/done/result clear immediately, without waiting for a clock edge. DONE_HOLD=1 run: done stays high until the next start.
